// File: rtl/vga_frame_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_frame_reader_if : memory read port between the VGA reader and the      |
// |                       display-side port of the dual-port data memory      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vga_frame_reader_if;
  logic [17:0] address_vga;
  logic [7:0]  color;

  modport master (output address_vga, input  color);
  modport slave  (input  address_vga, output color);
endinterface
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_frame_reader : 640x480@60 VGA timing, linear image fetch from memory   |
// |                    and DE1-SoC DAC outputs, all in the pixel-clock domain  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_frame_reader #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned IMG_X0   = 0,
  parameter int unsigned IMG_Y0   = 0,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  vga_frame_reader_if.master mem,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  typedef struct packed {
    logic fs;
    logic in_img;
    logic vs_n;
    logic hs_n;
    logic vis;
  } tap_t;

  localparam tap_t TAP_IDLE = '{fs: 1'b0, in_img: 1'b0, vs_n: 1'b1, hs_n: 1'b1, vis: 1'b0};

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [17:0]   pix_q, pix_d;
  logic [31:0]   h_ext, v_ext;
  logic          h_last, v_last;
  tap_t          tap0;
  tap_t          dly_q [READ_LAT];
  tap_t          tap_out;

  logic          hs_q, vs_q, blank_q, fs_q;
  logic [7:0]    rgb_q;

  assign h_ext  = 32'(h_cnt_q);
  assign v_ext  = 32'(v_cnt_q);
  assign h_last = (h_ext == H_TOT - 1);
  assign v_last = (v_ext == V_TOT - 1);

  // Window tests use unsigned subtraction: a counter below the window start
  // wraps to a huge value and falls outside the width test.
  always_comb begin
    tap0        = TAP_IDLE;
    tap0.vis    = (h_ext < H_VIS) && (v_ext < V_VIS);
    tap0.hs_n   = !((h_ext - (H_VIS + H_FP)) < H_SYNC);
    tap0.vs_n   = !((v_ext - (V_VIS + V_FP)) < V_SYNC);
    tap0.in_img = ((h_ext - IMG_X0) < IMG_W) && ((v_ext - IMG_Y0) < IMG_H);
    tap0.fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end
    pix_d = pix_q;
    if (h_last && v_last) begin
      pix_d = '0;
    end else if (tap0.in_img) begin
      pix_d = pix_q + 18'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pix_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pix_q   <= pix_d;
    end
  end

  // Pixel counter walks the image row-major, so it equals the linear index.
  assign mem.address_vga = tap0.in_img ? pix_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LAT); i++) begin
        dly_q[i] <= TAP_IDLE;
      end
    end else begin
      dly_q[0] <= tap0;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign tap_out = dly_q[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= 8'd0;
    end else begin
      hs_q    <= tap_out.hs_n;
      vs_q    <= tap_out.vs_n;
      blank_q <= tap_out.vis;
      fs_q    <= tap_out.fs;
      rgb_q   <= (tap_out.in_img && tap_out.vis) ? mem.color : 8'd0;
    end
  end

  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q;
  assign vga_g       = rgb_q;
  assign vga_b       = rgb_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_frame_reader : randomized bench with a behavioural screen model     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_frame_reader;

  // Horizontal timing at full size; vertical shortened so whole frames fit.
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 20,  VF = 2,  VS = 2,  VB = 3;
  localparam int IW = 256, IH = 16, X0 = 512, Y0 = 8, RL = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int PIPE = RL + 1;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vga_frame_reader_if mif();
  logic       vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_frame_reader #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0), .IMG_Y0(Y0), .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .mem(mif),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // Memory: random image contents, read data appears RL cycles after address.
  logic [7:0]  img_mem [4096];
  logic [17:0] apipe [RL];
  always @(posedge clk) begin
    apipe[0] <= mif.address_vga;
    for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
  end
  assign mif.color = img_mem[apipe[RL-1][11:0]];

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic r_s = 1'b1;
  int vs_low = 0;

  always @(posedge clk) begin
    r_s <= reset;
    t   <= reset ? 0 : t + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [17:0] m_addr(input int h, input int v);
    if (h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH)
      return 18'((v - Y0) * IW + (h - X0));
    return 18'd0;
  endfunction

  always @(negedge clk) begin : compare
    int h, v, s, ph, pv;
    logic [17:0] a;
    logic e_vis, e_hs, e_vs, e_fs;
    logic [7:0] e_rgb;
    chk("sync_n", vga_sync_n, 1'b0);
    if (r_s) begin
      vs_low = 0;
      chk("rst_hsync", vga_hsync, 1'b1);
      chk("rst_vsync", vga_vsync, 1'b1);
      chk("rst_blank", vga_blank_n, 1'b0);
      chk("rst_r", vga_r, 8'd0);
      chk("rst_g", vga_g, 8'd0);
      chk("rst_b", vga_b, 8'd0);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_addr", mif.address_vga, 18'd0);
    end else begin
      h = t % HT;
      v = (t / HT) % VT;
      chk("addr", mif.address_vga, m_addr(h, v));
      e_vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 8'd0;
      if (t >= PIPE) begin
        s  = t - PIPE;
        ph = s % HT;
        pv = (s / HT) % VT;
        e_vis = (ph < HV) && (pv < VV);
        e_hs  = !(ph >= HV + HF && ph < HV + HF + HS);
        e_vs  = !(pv >= VV + VF && pv < VV + VF + VS);
        e_fs  = (ph == 0) && (pv == 0);
        a = m_addr(ph, pv);
        if (e_vis && ph >= X0 && ph < X0 + IW && pv >= Y0 && pv < Y0 + IH)
          e_rgb = img_mem[a[11:0]];
      end
      chk("hsync", vga_hsync, e_hs);
      chk("vsync", vga_vsync, e_vs);
      chk("blank_n", vga_blank_n, e_vis);
      chk("frame_start", frame_start, e_fs);
      chk("r", vga_r, e_rgb);
      chk("g", vga_g, e_rgb);
      chk("b", vga_b, e_rgb);

      // Hand-computed anchor points for this configuration (PIPE = 3).
      if (t == 658) chk("lit_hs_before", vga_hsync, 1'b1);
      if (t == 659) chk("lit_hs_fall", vga_hsync, 1'b0);
      if (t == 754) chk("lit_hs_last", vga_hsync, 1'b0);
      if (t == 755) chk("lit_hs_rise", vga_hsync, 1'b1);
      if (t == 2)   chk("lit_blank_pre", vga_blank_n, 1'b0);
      if (t == 3)   chk("lit_blank_on", vga_blank_n, 1'b1);
      if (t == 642) chk("lit_blank_end", vga_blank_n, 1'b1);
      if (t == 643) chk("lit_blank_off", vga_blank_n, 1'b0);
      if (t == 3)   chk("lit_fs_first", frame_start, 1'b1);
      if (t == 21602) chk("lit_fs_pre", frame_start, 1'b0);
      if (t == 21603) chk("lit_fs_second", frame_start, 1'b1);
      if (t == 6912) chk("lit_addr_edge", mif.address_vga, 18'd0);
      if (t == 6913) chk("lit_addr_1", mif.address_vga, 18'd1);
      if (t == 7100) chk("lit_addr_offscreen", mif.address_vga, 18'd188);
      if (t == 7168) chk("lit_addr_past_img", mif.address_vga, 18'd0);
      if (t == 7712) chk("lit_addr_row1", mif.address_vga, 18'd256);
      if (t == 19167) chk("lit_addr_last", mif.address_vga, 18'd4095);
      if (t == 6916) chk("lit_rgb_first", vga_r, img_mem[1]);
      if (t == 7103) chk("lit_rgb_blanked", vga_r, 8'd0);
      if (t >= 3 && t < 21603 && !vga_vsync) vs_low++;
      if (t == 21603) chk("lit_vsync_low_cycles", vs_low, 1600);
    end
  end

  initial begin
    int run1;
    for (int i = 0; i < 4096; i++) img_mem[i] = 8'($urandom);
    run1 = $urandom_range(21700, 23000);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (run1) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * FRAME + 500) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
